// File: rtl/axis_snoop_arbiter.sv
// Packet-granular round-robin merge of NUM_CH AXI-stream snoop channels into one stream.
// Optional per-channel forwarded-packet counters are enabled with SNOOP_ARB_PKT_CNT_EN.
module axis_snoop_arbiter #(
    parameter int PORT_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                           AXIS_ACLK,
    input  logic                           AXIS_ARESETN,
    input  logic [NUM_CH-1:0]              S_AXIS_TVALID,
    input  logic [NUM_CH*PORT_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [NUM_CH-1:0]              S_AXIS_TLAST,
    output logic [NUM_CH-1:0]              S_AXIS_TREADY,
    output logic                           M_AXIS_TVALID,
    output logic [PORT_WIDTH-1:0]          M_AXIS_TDATA,
    output logic                           M_AXIS_TLAST,
    output logic [$clog2(NUM_CH)-1:0]      M_AXIS_TUSER,
    input  logic                           M_AXIS_TREADY
`ifdef SNOOP_ARB_PKT_CNT_EN
    ,
    output logic [NUM_CH*32-1:0]           PKT_COUNT
`endif
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CH_W-1:0] grant_reg, grant_next;
    logic [CH_W-1:0] last_reg,  last_next;

    logic [PORT_WIDTH-1:0] ch_data [NUM_CH];
    logic                  req_found;
    logic [CH_W-1:0]       req_sel;
    logic [CH_W-1:0]       rr_cand;
    logic                  pkt_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = S_AXIS_TDATA[gi*PORT_WIDTH +: PORT_WIDTH];
        end
    endgenerate

    // Round-robin search starting just after the channel that last completed a packet.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        rr_cand   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            rr_cand = CH_W'((int'(last_reg) + k) % NUM_CH);
            if (!req_found && S_AXIS_TVALID[rr_cand]) begin
                req_found = 1'b1;
                req_sel   = rr_cand;
            end
        end
    end

    assign pkt_done = (state_reg == BUSY) && S_AXIS_TVALID[grant_reg]
                      && S_AXIS_TLAST[grant_reg] && M_AXIS_TREADY;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= CH_W'(NUM_CH - 1);
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        last_next     = last_reg;
        S_AXIS_TREADY = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TDATA  = ch_data[grant_reg];
        case (state_reg)
            IDLE: begin
                if (req_found) begin
                    grant_next = req_sel;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Pure passthrough of the granted channel; other channels see no ready.
                M_AXIS_TVALID            = S_AXIS_TVALID[grant_reg];
                M_AXIS_TLAST             = S_AXIS_TLAST[grant_reg];
                S_AXIS_TREADY[grant_reg] = M_AXIS_TREADY;
                if (pkt_done) begin
                    last_next  = grant_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign M_AXIS_TUSER = grant_reg;

`ifdef SNOOP_ARB_PKT_CNT_EN
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
                if (!AXIS_ARESETN) begin
                    cnt_reg <= '0;
                end else if (pkt_done && (grant_reg == CH_W'(gi))) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign PKT_COUNT[gi*32 +: 32] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: doc/axis_snoop_arbiter.md
# axis_snoop_arbiter

Packet-granular round-robin arbiter that merges NUM_CH AXI-stream snoop channels into one AXI-stream master. Each input is the master side of a per-channel snoop FIFO, which holds only whole packets. The arbiter grants one channel at a time, forwards that channel's packet to the single downstream consumer, and releases the grant only after the TLAST beat. Packets are never interleaved, and each output packet is tagged with its source channel.

## Interface
- PORT_WIDTH, 8: data width per channel in bits.
- NUM_CH, 4: number of input channels; legal range 2..16.
- CH_W, $clog2(NUM_CH): channel-index width. Localparam, not overridable.

Ports:
- AXIS_ACLK  in  1  single clock; all logic is rising-edge.
- AXIS_ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TVALID  in  NUM_CH  per-channel valid.
- S_AXIS_TDATA  in  NUM_CH*PORT_WIDTH  per-channel data; channel i occupies bits [i*PORT_WIDTH +: PORT_WIDTH].
- S_AXIS_TLAST  in  NUM_CH  per-channel end of packet.
- S_AXIS_TREADY  out  NUM_CH  per-channel ready.
- M_AXIS_TVALID  out  1  merged valid.
- M_AXIS_TDATA  out  PORT_WIDTH  merged data.
- M_AXIS_TLAST  out  1  merged end of packet.
- M_AXIS_TUSER  out  CH_W  source channel of the current packet.
- M_AXIS_TREADY  in  1  downstream ready.
- PKT_COUNT  out  NUM_CH*32  per-channel forwarded-packet count. Present only with SNOOP_ARB_PKT_CNT_EN.

## Operation
- State machine has two states, IDLE and BUSY. Registers: state, grant (CH_W bits), last (CH_W bits).
- IDLE:
  - All S_AXIS_TREADY = 0 and M_AXIS_TVALID = 0.
  - If any S_AXIS_TVALID is high, select the first asserted channel searching from last+1 upward, wrapping modulo NUM_CH.
  - On the next edge, load grant with the selected channel and move to BUSY.
- BUSY, combinational passthrough of the granted channel only:
  - M_AXIS_TVALID = S_AXIS_TVALID[grant].
  - M_AXIS_TDATA and M_AXIS_TLAST come from channel grant.
  - S_AXIS_TREADY[grant] = M_AXIS_TREADY; all other TREADY bits = 0.
  - M_AXIS_TUSER = grant, held constant for the whole packet.
- Packet end: on a beat where M_AXIS_TVALID, M_AXIS_TREADY and M_AXIS_TLAST are all high, load last with grant and return to IDLE on that edge.
- Requests that arrive during BUSY are ignored until the next IDLE cycle. There is no preemption and no packet-length limit.
- A valid that drops mid-packet on the granted channel stalls the output. The grant is held and no beats are taken from other channels.
- Single-beat packets (TLAST on the first beat) are legal. They occupy one BUSY cycle.
- The fairness pointer last changes only on packet completion, never on selection alone.

## Timing
- Reset values (asynchronous, applied immediately):
  - state = IDLE, grant = 0, last = NUM_CH-1, so channel 0 has first priority.
  - All S_AXIS_TREADY = 0, M_AXIS_TVALID = 0, M_AXIS_TUSER = 0, PKT_COUNT = 0.
- Latency: a channel's valid sampled in IDLE produces its first output beat in the next cycle. The path from S to M is zero-cycle combinational in BUSY.
- One mandatory IDLE bubble separates consecutive packets. Peak throughput for a packet of L beats is L/(L+1).
- Simultaneous requests are resolved by round-robin from last+1.
- If the granted channel is the only requester, it is re-granted after the bubble.
- Reset mid-packet: the packet is abandoned and outputs go to reset values in the same cycle. The upstream FIFOs are reset by the same AXIS_ARESETN.
- M_AXIS_TUSER is meaningful only while M_AXIS_TVALID is high. It holds grant in IDLE.

## Configuration
- Macro: SNOOP_ARB_PKT_CNT_EN.
- Defined: PKT_COUNT port and NUM_CH 32-bit counters are present.
  - Counter i increments by 1 on each completed TLAST beat forwarded from channel i.
  - Counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- Undefined: no counters and no PKT_COUNT port. All other behaviour is identical.

## Test plan
- Reset, then channel 2 sends a 3-beat packet (0x11, 0x22, 0x33) with M_AXIS_TREADY held at 1 -> output is 0x11, 0x22, 0x33 with TUSER=2, TLAST on beat 3, first beat one cycle after TVALID.
- Channels 0–3 all hold 2-beat packets at once -> grant order is 0, 1, 2, 3, 0, with one idle cycle between packets.
- Channel 1 mid-packet while M_AXIS_TREADY toggles 1,0,1 and channel 0 asserts TVALID -> no channel 0 beat until channel 1's TLAST. S_AXIS_TREADY[0] stays 0 and data is not duplicated or lost.
- Channel 3 sends a single-beat packet 0xA5 with TLAST, then channel 0 is pending -> 0xA5 is output with TUSER=3, one IDLE cycle follows, then channel 0 is granted.
- AXIS_ARESETN asserted during beat 2 of a 5-beat packet -> M_AXIS_TVALID and all TREADY go 0 immediately. After release, the next grant starts from channel 0.
- With SNOOP_ARB_PKT_CNT_EN: channel 1 sends 4 packets and channel 2 sends 1 -> PKT_COUNT[1]=4, PKT_COUNT[2]=1, others 0.
